// File: rtl/calc_mp_core.sv
// calc_mp_core: multi-port calculator core. Each port has a request FIFO with
// backpressure. A round-robin arbiter issues one request per cycle into a
// two-stage ALU pipeline with operand forwarding. Each response goes back to
// the originating port with the request's tag.
// Optional feature: define CALC_SAT_EN for saturating add/sub instead of error.
module calc_mp_core #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned REG_DEPTH  = 16,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned RADDR_W    = $clog2(REG_DEPTH)
) (
  input  logic                         c_clk,
  input  logic                         reset_n,
  input  logic [NUM_PORTS*4-1:0]       req_cmd,
  input  logic [NUM_PORTS*TAG_W-1:0]   req_tag,
  input  logic [NUM_PORTS*RADDR_W-1:0] req_d1,
  input  logic [NUM_PORTS*RADDR_W-1:0] req_d2,
  input  logic [NUM_PORTS*RADDR_W-1:0] req_r1,
  input  logic [NUM_PORTS*DATA_W-1:0]  req_data,
  output logic [NUM_PORTS-1:0]         req_ready,
  output logic [NUM_PORTS*2-1:0]       out_resp,
  output logic [NUM_PORTS*TAG_W-1:0]   out_tag,
  output logic [NUM_PORTS*DATA_W-1:0]  out_data
);

  localparam int unsigned PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned SH_W    = $clog2(DATA_W);
  localparam int unsigned OFF_R1  = DATA_W;
  localparam int unsigned OFF_D2  = OFF_R1 + RADDR_W;
  localparam int unsigned OFF_D1  = OFF_D2 + RADDR_W;
  localparam int unsigned OFF_TAG = OFF_D1 + RADDR_W;
  localparam int unsigned OFF_CMD = OFF_TAG + TAG_W;
  localparam int unsigned ENTRY_W = OFF_CMD + 4;

  localparam logic [3:0] CMD_ADD   = 4'b0001;
  localparam logic [3:0] CMD_SUB   = 4'b0010;
  localparam logic [3:0] CMD_SHL   = 4'b0101;
  localparam logic [3:0] CMD_SHR   = 4'b0110;
  localparam logic [3:0] CMD_STORE = 4'b1001;
  localparam logic [3:0] CMD_FETCH = 4'b1010;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  // FIFO storage and control
  logic [ENTRY_W-1:0] fifo_mem [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr   [NUM_PORTS];
  logic [PTR_W-1:0]   rd_ptr   [NUM_PORTS];
  logic [CNT_W-1:0]   count    [NUM_PORTS];
  logic [CNT_W-1:0]   cnt_nxt_c [NUM_PORTS];
  logic [ENTRY_W-1:0] entry_in_c [NUM_PORTS];
  logic [NUM_PORTS-1:0] ready_q, push_c, pop_c;
  logic [PORT_W-1:0]  rr_ptr;

  // Arbitration and issue
  logic               grant_valid_c;
  logic [PORT_W-1:0]  grant_port_c;
  int unsigned        arb_idx;
  logic [ENTRY_W-1:0] iss_entry_c;
  logic [RADDR_W-1:0] iss_d1_c, iss_d2_c;
  logic [DATA_W-1:0]  op_a_c, op_b_c;

  // Stage 1 registers
  logic               s1_valid;
  logic [PORT_W-1:0]  s1_port;
  logic [3:0]         s1_cmd;
  logic [TAG_W-1:0]   s1_tag;
  logic [RADDR_W-1:0] s1_r1;
  logic [DATA_W-1:0]  s1_data, s1_a, s1_b;

  // Stage 2 execute results
  logic [DATA_W:0]    sum_c;
  logic               wr_en_c;
  logic [DATA_W-1:0]  wr_val_c, rdata_c;
  logic [1:0]         resp_c;

  logic [DATA_W-1:0]  regs [REG_DEPTH];

  assign req_ready = ready_q;

  // Per-port push/pop decisions and next occupancy
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      entry_in_c[p] = {req_cmd[4*p +: 4], req_tag[TAG_W*p +: TAG_W],
                       req_d1[RADDR_W*p +: RADDR_W], req_d2[RADDR_W*p +: RADDR_W],
                       req_r1[RADDR_W*p +: RADDR_W], req_data[DATA_W*p +: DATA_W]};
      push_c[p]    = ready_q[p] && (req_cmd[4*p +: 4] != 4'b0000);
      pop_c[p]     = grant_valid_c && (grant_port_c == PORT_W'(p));
      cnt_nxt_c[p] = count[p] + CNT_W'(push_c[p]) - CNT_W'(pop_c[p]);
    end
  end

  // Round-robin grant starting at rr_ptr among non-empty FIFOs
  always_comb begin
    grant_valid_c = 1'b0;
    grant_port_c  = '0;
    arb_idx       = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      arb_idx = (32'(rr_ptr) + i) % NUM_PORTS;
      if (!grant_valid_c && (count[arb_idx] != '0)) begin
        grant_valid_c = 1'b1;
        grant_port_c  = PORT_W'(arb_idx);
      end
    end
  end

  // Operand read for the granted entry, forwarding the stage-2 write
  always_comb begin
    iss_entry_c = fifo_mem[grant_port_c][rd_ptr[grant_port_c]];
    iss_d1_c    = iss_entry_c[OFF_D1 +: RADDR_W];
    iss_d2_c    = iss_entry_c[OFF_D2 +: RADDR_W];
    op_a_c      = regs[iss_d1_c];
    op_b_c      = regs[iss_d2_c];
    if (wr_en_c && (s1_r1 == iss_d1_c)) op_a_c = wr_val_c;
    if (wr_en_c && (s1_r1 == iss_d2_c)) op_b_c = wr_val_c;
  end

  // Stage-2 ALU: result, write enable and response code
  always_comb begin
    sum_c    = {1'b0, s1_a} + {1'b0, s1_b};
    wr_en_c  = 1'b0;
    wr_val_c = '0;
    rdata_c  = '0;
    resp_c   = RESP_ERR;
    if (s1_valid) begin
      case (s1_cmd)
        CMD_ADD: begin
          if (!sum_c[DATA_W]) begin
            wr_en_c  = 1'b1;
            wr_val_c = sum_c[DATA_W-1:0];
            resp_c   = RESP_OK;
          end else begin
`ifdef CALC_SAT_EN
            wr_en_c  = 1'b1;
            wr_val_c = '1;
            resp_c   = RESP_OK;
`else
            resp_c   = RESP_ERR;
`endif
          end
        end
        CMD_SUB: begin
          if (s1_b <= s1_a) begin
            wr_en_c  = 1'b1;
            wr_val_c = s1_a - s1_b;
            resp_c   = RESP_OK;
          end else begin
`ifdef CALC_SAT_EN
            wr_en_c  = 1'b1;
            wr_val_c = '0;
            resp_c   = RESP_OK;
`else
            resp_c   = RESP_ERR;
`endif
          end
        end
        CMD_SHL: begin
          wr_en_c  = 1'b1;
          wr_val_c = s1_a << s1_b[SH_W-1:0];
          resp_c   = RESP_OK;
        end
        CMD_SHR: begin
          wr_en_c  = 1'b1;
          wr_val_c = s1_a >> s1_b[SH_W-1:0];
          resp_c   = RESP_OK;
        end
        CMD_STORE: begin
          wr_en_c  = 1'b1;
          wr_val_c = s1_data;
          resp_c   = RESP_OK;
        end
        CMD_FETCH: begin
          rdata_c  = s1_a;
          resp_c   = RESP_OK;
        end
        default: resp_c = RESP_ERR;
      endcase
    end
  end

  // FIFO pointers, occupancy, ready and round-robin pointer
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
      end
      ready_q <= '0;
      rr_ptr  <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (push_c[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop_c[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
        count[p]   <= cnt_nxt_c[p];
        ready_q[p] <= (cnt_nxt_c[p] != CNT_W'(FIFO_DEPTH));
      end
      if (grant_valid_c)
        rr_ptr <= (grant_port_c == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_port_c + 1'b1;
    end
  end

  // FIFO payload storage
  always_ff @(posedge c_clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++)
      if (push_c[p]) fifo_mem[p][wr_ptr[p]] <= entry_in_c[p];
  end

  // Stage 1: capture issued request and forwarded operands
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_port  <= '0;
      s1_cmd   <= '0;
      s1_tag   <= '0;
      s1_r1    <= '0;
      s1_data  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= grant_valid_c;
      s1_port  <= grant_port_c;
      s1_cmd   <= iss_entry_c[OFF_CMD +: 4];
      s1_tag   <= iss_entry_c[OFF_TAG +: TAG_W];
      s1_r1    <= iss_entry_c[OFF_R1 +: RADDR_W];
      s1_data  <= iss_entry_c[DATA_W-1:0];
      s1_a     <= op_a_c;
      s1_b     <= op_b_c;
    end
  end

  // Register file write-back
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < REG_DEPTH; r++) regs[r] <= '0;
    end else if (wr_en_c) begin
      regs[s1_r1] <= wr_val_c;
    end
  end

  // Response outputs: one cycle for the completing port, zero elsewhere
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_resp <= '0;
      out_tag  <= '0;
      out_data <= '0;
    end else begin
      out_resp <= '0;
      out_tag  <= '0;
      out_data <= '0;
      if (s1_valid) begin
        out_resp[2*s1_port +: 2]          <= resp_c;
        out_tag[TAG_W*s1_port +: TAG_W]   <= s1_tag;
        out_data[DATA_W*s1_port +: DATA_W] <= rdata_c;
      end
    end
  end

endmodule

// File: tb/tb_calc_mp_core.sv
// Directed self-checking bench for calc_mp_core (default parameters).
module tb_calc_mp_core;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int RW = 4;

  localparam logic [3:0] C_ADD = 4'b0001, C_SUB = 4'b0010, C_SHL = 4'b0101,
                         C_SHR = 4'b0110, C_STO = 4'b1001, C_FET = 4'b1010,
                         C_BAD = 4'b0011;
  localparam logic [1:0] OK = 2'b01, ERR = 2'b10;
`ifdef CALC_SAT_EN
  localparam logic [1:0]  OVF_RESP = 2'b01;
  localparam logic [31:0] R3_AFTER = 32'hFFFF_FFFF;
`else
  localparam logic [1:0]  OVF_RESP = 2'b10;
  localparam logic [31:0] R3_AFTER = 32'd9;
`endif

  logic             c_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NP*4-1:0]  req_cmd = '0;
  logic [NP*TW-1:0] req_tag = '0;
  logic [NP*RW-1:0] req_d1 = '0, req_d2 = '0, req_r1 = '0;
  logic [NP*DW-1:0] req_data = '0;
  logic [NP-1:0]    req_ready;
  logic [NP*2-1:0]  out_resp;
  logic [NP*TW-1:0] out_tag;
  logic [NP*DW-1:0] out_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Stream scoreboard
  logic [1:0]   sb_tag [NP][64];
  int           sb_wr [NP];
  int           sb_rd [NP];
  logic [1:0]   cur_tag [NP];
  bit           saw_nr [NP];
  logic [NP-1:0] acc_now;
  int           acc_total = 0;
  int           got_total = 0;

  calc_mp_core dut (
    .c_clk(c_clk), .reset_n(reset_n),
    .req_cmd(req_cmd), .req_tag(req_tag), .req_d1(req_d1), .req_d2(req_d2),
    .req_r1(req_r1), .req_data(req_data), .req_ready(req_ready),
    .out_resp(out_resp), .out_tag(out_tag), .out_data(out_data)
  );

  always #5 c_clk = ~c_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                         input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] r1,
                         input logic [31:0] data);
    req_cmd[4*p +: 4]    = cmd;
    req_tag[TW*p +: TW]  = tag;
    req_d1[RW*p +: RW]   = d1;
    req_d2[RW*p +: RW]   = d2;
    req_r1[RW*p +: RW]   = r1;
    req_data[DW*p +: DW] = data;
  endtask

  task automatic clr_req(input int p);
    set_req(p, 4'b0000, 2'b00, 4'd0, 4'd0, 4'd0, 32'd0);
  endtask

  task automatic clr_all();
    for (int p = 0; p < NP; p++) clr_req(p);
  endtask

  task automatic check_done(input string name, input int p, input logic [1:0] eresp,
                            input logic [1:0] etag, input logic [31:0] edata);
    logic [NP*2-1:0] ev;
    ev = '0;
    ev[2*p +: 2] = eresp;
    chk({name, "_resp"}, 64'(out_resp), 64'(ev));
    chk({name, "_tag"},  64'(out_tag[TW*p +: TW]), 64'(etag));
    chk({name, "_data"}, 64'(out_data[DW*p +: DW]), 64'(edata));
  endtask

  // Single uncontended request: accept at edge k, idle after k+1, done after k+2
  task automatic do_op(input string name, input int p, input logic [3:0] cmd,
                       input logic [1:0] tag, input logic [3:0] d1, input logic [3:0] d2,
                       input logic [3:0] r1, input logic [31:0] data,
                       input logic [1:0] eresp, input logic [31:0] edata);
    set_req(p, cmd, tag, d1, d2, r1, data);
    tick();
    clr_req(p);
    tick();
    chk({name, "_idle"}, 64'(out_resp), 64'd0);
    tick();
    check_done(name, p, eresp, tag, edata);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clr_all();
    tick();
    tick();
    chk("rst_ready_low", 64'(req_ready), 64'd0);
    chk("rst_resp_zero", 64'(out_resp), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_ready_up", 64'(req_ready), 64'hF);
  endtask

  task automatic observe();
    int nz = 0;
    for (int p = 0; p < NP; p++) begin
      if (out_resp[2*p +: 2] != 2'b00) begin
        nz++;
        got_total++;
        chk("sb_pending", 64'(sb_rd[p] < sb_wr[p]), 64'd1);
        if (sb_rd[p] < sb_wr[p]) begin
          chk("stream_tag",  64'(out_tag[TW*p +: TW]), 64'(sb_tag[p][sb_rd[p]]));
          chk("stream_resp", 64'(out_resp[2*p +: 2]), 64'd1);
          chk("stream_data", 64'(out_data[DW*p +: DW]), 64'd0);
          sb_rd[p]++;
        end
      end
    end
    chk("one_per_cycle", 64'(nz <= 1), 64'd1);
  endtask

  initial begin
    // 1: basic store/add/fetch on port 0
    do_reset();
    do_op("t1_st1",  0, C_STO, 2'd0, 4'd0, 4'd0, 4'd1, 32'd5, OK, 32'd0);
    do_op("t1_st2",  0, C_STO, 2'd1, 4'd0, 4'd0, 4'd2, 32'd7, OK, 32'd0);
    do_op("t1_add",  0, C_ADD, 2'd2, 4'd1, 4'd2, 4'd3, 32'd0, OK, 32'd0);
    do_op("t1_fet",  0, C_FET, 2'd3, 4'd3, 4'd0, 4'd0, 32'd0, OK, 32'd12);

    // 2: overflow/underflow and shifts
    do_op("t2_st3",  0, C_STO, 2'd0, 4'd0, 4'd0, 4'd3, 32'd9, OK, 32'd0);
    do_op("t2_st1",  0, C_STO, 2'd1, 4'd0, 4'd0, 4'd1, 32'hFFFF_FFFF, OK, 32'd0);
    do_op("t2_st2",  0, C_STO, 2'd2, 4'd0, 4'd0, 4'd2, 32'd1, OK, 32'd0);
    do_op("t2_ovf",  0, C_ADD, 2'd3, 4'd1, 4'd2, 4'd3, 32'd0, OVF_RESP, 32'd0);
    do_op("t2_fet3", 0, C_FET, 2'd0, 4'd3, 4'd0, 4'd0, 32'd0, OK, R3_AFTER);
    do_op("t2_unf",  0, C_SUB, 2'd1, 4'd2, 4'd1, 4'd5, 32'd0, OVF_RESP, 32'd0);
    do_op("t2_fet5", 0, C_FET, 2'd2, 4'd5, 4'd0, 4'd0, 32'd0, OK, 32'd0);
    do_op("t2_st6",  0, C_STO, 2'd3, 4'd0, 4'd0, 4'd6, 32'd1, OK, 32'd0);
    do_op("t2_st7",  0, C_STO, 2'd0, 4'd0, 4'd0, 4'd7, 32'd35, OK, 32'd0);
    do_op("t2_shl",  0, C_SHL, 2'd1, 4'd6, 4'd7, 4'd8, 32'd0, OK, 32'd0);
    do_op("t2_fet8", 0, C_FET, 2'd2, 4'd8, 4'd0, 4'd0, 32'd0, OK, 32'd8);
    do_op("t2_st9",  0, C_STO, 2'd3, 4'd0, 4'd0, 4'd9, 32'h8000_0000, OK, 32'd0);
    do_op("t2_shr",  0, C_SHR, 2'd0, 4'd9, 4'd7, 4'd10, 32'd0, OK, 32'd0);
    do_op("t2_fet10", 0, C_FET, 2'd1, 4'd10, 4'd0, 4'd0, 32'd0, OK, 32'h1000_0000);
    do_op("t2_sub",  0, C_SUB, 2'd2, 4'd7, 4'd6, 4'd11, 32'd0, OK, 32'd0);
    do_op("t2_fet11", 0, C_FET, 2'd3, 4'd11, 4'd0, 4'd0, 32'd0, OK, 32'd34);

    // 3: all ports in the same cycle after reset -> port order 0,1,2,3
    do_reset();
    for (int p = 0; p < NP; p++)
      set_req(p, C_ADD, 2'(3 - p), 4'd1, 4'd2, 4'(11 + p), 32'd0);
    tick();
    clr_all();
    tick();
    chk("t3_idle", 64'(out_resp), 64'd0);
    for (int p = 0; p < NP; p++) begin
      tick();
      check_done("t3_port", p, OK, 2'(3 - p), 32'd0);
    end
    tick();
    chk("t3_after", 64'(out_resp), 64'd0);

    // 4: back-to-back dependent adds on port 1 (forwarding)
    do_op("t4_st1", 1, C_STO, 2'd0, 4'd0, 4'd0, 4'd1, 32'd5, OK, 32'd0);
    do_op("t4_st2", 1, C_STO, 2'd1, 4'd0, 4'd0, 4'd2, 32'd7, OK, 32'd0);
    set_req(1, C_ADD, 2'd0, 4'd1, 4'd2, 4'd3, 32'd0);
    tick();
    set_req(1, C_ADD, 2'd1, 4'd3, 4'd3, 4'd4, 32'd0);
    tick();
    clr_req(1);
    chk("t4_idle", 64'(out_resp), 64'd0);
    tick();
    check_done("t4_add1", 1, OK, 2'd0, 32'd0);
    tick();
    check_done("t4_add2", 1, OK, 2'd1, 32'd0);
    do_op("t4_fet4", 1, C_FET, 2'd2, 4'd4, 4'd0, 4'd0, 32'd0, OK, 32'd24);
    do_op("t4_bad",  1, C_BAD, 2'd3, 4'd1, 4'd2, 4'd4, 32'd0, ERR, 32'd0);
    do_op("t4_fet4b", 1, C_FET, 2'd0, 4'd4, 4'd0, 4'd0, 32'd0, OK, 32'd24);

    // 5: all ports stream for 12 cycles
    do_reset();
    for (int p = 0; p < NP; p++) begin
      sb_wr[p] = 0;
      sb_rd[p] = 0;
      saw_nr[p] = 1'b0;
      cur_tag[p] = 2'd0;
      set_req(p, C_STO, 2'd0, 4'd0, 4'd0, 4'(p + 1), 32'h100 + 32'(p * 16));
    end
    for (int c = 0; c < 12; c++) begin
      acc_now = req_ready;
      for (int p = 0; p < NP; p++) begin
        if (acc_now[p]) begin
          sb_tag[p][sb_wr[p]] = cur_tag[p];
          sb_wr[p]++;
          acc_total++;
        end else begin
          saw_nr[p] = 1'b1;
        end
      end
      tick();
      observe();
      for (int p = 0; p < NP; p++) begin
        if (acc_now[p]) begin
          cur_tag[p] = cur_tag[p] + 2'd1;
          set_req(p, C_STO, cur_tag[p], 4'd0, 4'd0, 4'(p + 1),
                  32'h100 + 32'(p * 16) + 32'(cur_tag[p]));
        end
      end
    end
    clr_all();
    for (int c = 0; c < 30; c++) begin
      tick();
      observe();
    end
    chk("t5_totals", 64'(got_total), 64'(acc_total));
    for (int p = 0; p < NP; p++) begin
      chk("t5_drained", 64'(sb_rd[p]), 64'(sb_wr[p]));
      chk("t5_ready_drop", 64'(saw_nr[p]), 64'd1);
    end

    // 6: reset with requests queued and a response on the outputs
    for (int p = 0; p < 3; p++)
      set_req(p, C_STO, 2'(p), 4'd0, 4'd0, 4'd5, 32'hAA);
    tick();
    clr_all();
    tick();
    tick();
    chk("t6_busy", 64'(out_resp != '0), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_resp0",  64'(out_resp), 64'd0);
    chk("t6_tag0",   64'(out_tag), 64'd0);
    chk("t6_data0",  64'(out_data), 64'd0);
    chk("t6_ready0", 64'(req_ready), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t6_quiet", 64'(out_resp), 64'd0);
    end
    chk("t6_ready", 64'(req_ready), 64'hF);
    for (int r = 1; r <= 5; r++)
      do_op("t6_fet", 0, C_FET, 2'(r), 4'(r), 4'd0, 4'd0, 32'd0, OK, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_mp_core.md
Name: calc_mp_core

Overview:
- Parametrised successor to the four-port calculator core: NUM_PORTS request channels, configurable data width, register-file depth and tag width.
- Adds per-port request FIFOs with backpressure (req_ready), round-robin arbitration into a single 2-stage ALU pipeline, and operand forwarding.
- Sits where the calc3 core sits. Each response is routed back to its originating port with the request's tag.

Parameters:
- NUM_PORTS, 4, number of request/response channels (1..8)
- DATA_W, 32, operand/register width
- TAG_W, 2, tag width per port
- REG_DEPTH, 16, register-file entries; RADDR_W = $clog2(REG_DEPTH)
- FIFO_DEPTH, 2, per-port request FIFO entries (power of 2, >=2)

Ports:
- c_clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_cmd  in  NUM_PORTS*4  per-port command; port p at [4p+3:4p]
- req_tag  in  NUM_PORTS*TAG_W  per-port request tag
- req_d1  in  NUM_PORTS*RADDR_W  source register 1
- req_d2  in  NUM_PORTS*RADDR_W  source register 2
- req_r1  in  NUM_PORTS*RADDR_W  destination register
- req_data  in  NUM_PORTS*DATA_W  store data
- req_ready  out  NUM_PORTS  FIFO for port p not full
- out_resp  out  NUM_PORTS*2  00 idle, 01 success, 10 error/overflow
- out_tag  out  NUM_PORTS*TAG_W  tag of the completing request
- out_data  out  NUM_PORTS*DATA_W  fetch result; 0 for all other commands

Behaviour:
- Reset (reset_n low, async):
  - FIFOs emptied, pipeline flushed, register file cleared to 0, RR pointer set to port 0.
  - All out_* forced to 0; req_ready held 0.
  - req_ready goes to 1 on the first edge after deassertion.
  - Reset mid-operation drops all in-flight requests with no response.
- Commands:
  - 0000 nop.
  - 0001 add: r1 = d1 + d2.
  - 0010 sub: r1 = d1 - d2.
  - 0101 shl: r1 = d1 << d2val[$clog2(DATA_W)-1:0].
  - 0110 shr: logical, same shift-amount rule.
  - 1001 store: reg[r1] = data.
  - 1010 fetch: out_data = reg[d1].
  - Any other code: resp 10, no write.
- Arithmetic: unsigned.
  - Add carry-out -> resp 10, no write.
  - Sub with d2 > d1 -> resp 10, no write.
  - Shifts always succeed and write.
- Acceptance:
  - Port p accepts at an edge where req_cmd[p] != 0 and req_ready[p] = 1.
  - req_ready derives from registered full. A full FIFO never accepts, even when it is being popped in the same cycle.
  - A command presented while not ready is ignored: no response. Sender must hold it.
- Arbitration:
  - One issue per cycle among non-empty FIFOs, round-robin.
  - After granting p, highest priority becomes (p+1) mod NUM_PORTS.
- Pipeline:
  - Stage 1 (issue edge): pop FIFO, read operands.
  - Stage 2 (next edge): execute, write back, register outputs.
- Latency: request accepted at edge k into an empty system and uncontended -> issued at edge k+1 -> response visible after edge k+2 for exactly one cycle.
- Output hold: out_resp/out_tag/out_data for a port are 0 in every cycle with no completion.
- Forwarding: a stage-1 read of the register being written by stage 2 in the same cycle returns the new value. Back-to-back dependent ops are correct with no stall.
- Ordering: per-port responses return in acceptance order. At most one port completes per cycle.
- Throughput: sustained, 1 request/cycle aggregate.

Optional Feature:
- Macro CALC_SAT_EN.
- Defined:
  - Add overflow writes all-ones to r1, resp 01.
  - Sub underflow writes 0 to r1, resp 01.
- Undefined: overflow/underflow give resp 10 and no write.

Test Plan:
1. Reset, then port0 store reg1=5 tag0, store reg2=7 tag1, add r3=r1+r2 tag2, fetch d1=3 tag3.
   -> resps 01 with tags 0,1,2, then fetch data 12 tag3. Each response appears 2 edges after its acceptance edge.
2. reg1=0xFFFF_FFFF, reg2=1, add r3 (r3 previously 9).
   -> resp 10, fetch r3 = 9. With CALC_SAT_EN: resp 01, fetch r3 = 0xFFFF_FFFF.
3. All 4 ports present add in the same cycle after reset.
   -> responses on consecutive cycles in order port0, 1, 2, 3, each with its own tag.
4. Port1 add r3=r1+r2 (5+7) then immediately add r4=r3+r3.
   -> fetch r4 = 24 (forwarding). Also: cmd 0011 -> resp 10, no register change.
5. All ports stream a valid command every cycle for 12 cycles with FIFO_DEPTH=2.
   -> req_ready drops per port once its FIFO fills. Every accepted request gets exactly one response; none is duplicated or lost.
6. Assert reset_n low with 3 requests queued.
   -> outputs 0 immediately, no responses afterward, and all registers read 0 after release.
